// File: rtl/inv_chain_sequencer.sv
// inv_chain_sequencer: replays a level/hold schedule into an inverter chain and checks parity.
// Optional per-entry settle-latency tracking under `define INV_CHAIN_LATENCY_EN.
module inv_chain_sequencer #(
  parameter int STAGES = 3,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic              cfg_val,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [AW:0]       cfg_len,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [AW-1:0]     cur_idx,
  output logic [HOLD_W-1:0] lat_max
);

  localparam logic PAR = 1'(STAGES % 2);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              cin_q, cin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       len_q, len_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic              val_q  [DEPTH];
  logic [HOLD_W-1:0] hold_q [DEPTH];

  logic              exp_lvl;
  logic [AW:0]       len_in;
  logic [AW:0]       idx_nx;

  assign exp_lvl = val_q[idx_q] ^ PAR;
  assign len_in  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign idx_nx  = (AW+1)'(idx_q) + (AW+1)'(1);

  // Schedule RAM survives reset; frozen while a run is active.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_q) begin
      val_q[cfg_addr]  <= cfg_val;
      hold_q[cfg_addr] <= cfg_hold;
    end
  end

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mis_d   = 1'b0;
    err_d   = err_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d  = '0;
          idx_d  = '0;
          done_d = 1'b0;
          len_d  = len_in;
          if (len_in == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
            busy_d  = 1'b1;
          end
        end
      end
      S_APPLY: begin
        cin_d   = val_q[idx_q];
        cnt_d   = (hold_q[idx_q] == '0) ? HOLD_W'(1)
                                        : hold_q[idx_q];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cnt_d = cnt_q - HOLD_W'(1);
        if (cnt_q <= HOLD_W'(1)) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (chain_out != exp_lvl) begin
          mis_d = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (idx_nx == len_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign chain_in = cin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;
  assign cur_idx  = idx_q;

`ifdef INV_CHAIN_LATENCY_EN
  logic [HOLD_W-1:0] lat_q, lat_d;
  logic [HOLD_W-1:0] lmax_q, lmax_d;
  logic              hit_q, hit_d;

  // Latency = HOLD cycles seen before the chain first settles.
  always_comb begin
    lat_d  = lat_q;
    hit_d  = hit_q;
    lmax_d = lmax_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lmax_d = '0;
        end
      end
      S_APPLY: begin
        lat_d = '0;
        hit_d = 1'b0;
      end
      S_HOLD: begin
        if (!hit_q) begin
          if (chain_out == exp_lvl) begin
            hit_d = 1'b1;
          end else begin
            lat_d = lat_q + HOLD_W'(1);
          end
        end
      end
      S_SAMPLE: begin
        if (lat_q > lmax_q) begin
          lmax_d = lat_q;
        end
      end
      default: begin
        lat_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q  <= '0;
      lmax_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      lat_q  <= lat_d;
      lmax_q <= lmax_d;
      hit_q  <= hit_d;
    end
  end

  assign lat_max = lmax_q;
`else
  assign lat_max = '0;
`endif

endmodule

// File: tb/tb_inv_chain_sequencer.sv
// tb_inv_chain_sequencer: table vectors, corner sequences and randomized
// schedules checked against a timeline model of the sequencer.
module tb_inv_chain_sequencer;

  localparam int STAGES = 3;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 8;
  localparam int ERR_W  = 8;
  localparam int AW     = 3;
  localparam bit PAR    = (STAGES % 2) == 1;
`ifdef INV_CHAIN_LATENCY_EN
  localparam int LAT_EXP = 3;
`else
  localparam int LAT_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic              cfg_val = 1'b0;
  logic [HOLD_W-1:0] cfg_hold = '0;
  logic [AW:0]       cfg_len = '0;
  logic              chain_in, chain_out;
  logic              busy, done, mismatch;
  logic [ERR_W-1:0]  err_cnt;
  logic [AW-1:0]     cur_idx;
  logic [HOLD_W-1:0] lat_max;

  logic              s_cin, s_busy, s_done, s_mis;
  logic [1:0]        s_err;
  logic [AW-1:0]     s_idx;
  logic [HOLD_W-1:0] s_lat;

  int   mode = 0;
  bit   fault_now = 1'b0;
  logic [2:0] dly = '0;

  bit sv  [DEPTH];
  int sh  [DEPTH];
  bit flt [DEPTH];
  bit cin_model = 1'b0;
  int checks = 0;
  int errors = 0;

  inv_chain_sequencer #(
    .STAGES(STAGES), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_val(cfg_val), .cfg_hold(cfg_hold),
    .cfg_len(cfg_len), .chain_in(chain_in), .chain_out(chain_out),
    .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt),
    .cur_idx(cur_idx), .lat_max(lat_max)
  );

  // Narrow-counter instance wired as an even-parity (faulty) chain.
  inv_chain_sequencer #(
    .STAGES(STAGES), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .ERR_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_val(cfg_val), .cfg_hold(cfg_hold),
    .cfg_len(cfg_len), .chain_in(s_cin), .chain_out(s_cin),
    .busy(s_busy), .done(s_done), .mismatch(s_mis), .err_cnt(s_err),
    .cur_idx(s_idx), .lat_max(s_lat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[1:0], chain_in};

  always_comb begin
    chain_out = chain_in ^ PAR;
    case (mode)
      1: chain_out = chain_in;
      2: chain_out = dly[2] ^ PAR;
      3: chain_out = chain_in ^ PAR ^ fault_now;
      default: chain_out = chain_in ^ PAR;
    endcase
  end

  typedef struct {
    int len;
    int md;
    int cyc;
    int err;
    bit cin;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  // Cycle offset (from the accepting edge) where entry k enters APPLY.
  function automatic int tstart(input int k);
    int t = 0;
    for (int i = 0; i < k; i++) t += eff(sh[i]) + 2;
    return t;
  endfunction

  function automatic int exp_err(input int len, input int md, input int cap);
    int n = 0;
    for (int i = 0; i < len; i++) begin
      if (md == 1 || (md == 3 && flt[i])) n++;
    end
    return (n > cap) ? cap : n;
  endfunction

  task automatic cfg_write(input int a, input bit v, input int h);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a[AW-1:0];
    cfg_val  = v;
    cfg_hold = h[HOLD_W-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    sv[a] = v;
    sh[a] = h;
  endtask

  task automatic run(input int len, input int md, input int rst_at,
                     input bit disturb, output int ncyc, output int npulse,
                     output int wbad, output bit bseen);
    int m, tl, e;
    bit cin;
    mode   = md;
    tl     = tstart(len);
    npulse = 0;
    wbad   = 0;
    bseen  = 1'b0;
    ncyc   = -1;
    @(negedge clk);
    cfg_len = len[AW:0];
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m = 0;
    forever begin
      e   = 0;
      cin = cin_model;
      for (int k = 0; k < len; k++) begin
        if (m >= tstart(k)) e = k;
        if (m >= tstart(k) + 1) cin = sv[k];
      end
      if (mismatch) npulse++;
      if (busy) bseen = 1'b1;
      if (busy !== (m < tl)) wbad++;
      if (done !== (m >= tl)) wbad++;
      if (chain_in !== cin) wbad++;
      if (int'(cur_idx) != e) wbad++;
      fault_now = flt[e];
      if (m == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        cin_model = 1'b0;
        ncyc = -2;
        return;
      end
      if (done) begin
        ncyc = m;
        break;
      end
      if (m > tl + 5) break;
      if (disturb && m == 5) begin
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_val  = ~sv[0];
        cfg_hold = 8'd30;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      m++;
      if (disturb && m == 6) begin
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
    if (len > 0) cin_model = sv[len-1];
  endtask

  initial begin
    int nc, np, wb, len;
    bit bs;
    bit vals [8];
    int holds [8];
    vals  = '{0, 1, 0, 1, 1, 0, 0, 1};
    holds = '{5, 7, 20, 1, 0, 0, 2, 3};
    tbl[0] = '{len: 4, md: 0, cyc: 41, err: 0, cin: 1'b1};
    tbl[1] = '{len: 4, md: 1, cyc: 41, err: 4, cin: 1'b1};
    tbl[2] = '{len: 2, md: 0, cyc: 16, err: 0, cin: 1'b1};
    tbl[3] = '{len: 3, md: 1, cyc: 38, err: 3, cin: 1'b0};
    tbl[4] = '{len: 0, md: 0, cyc: 0,  err: 0, cin: 1'b0};
    tbl[5] = '{len: 8, md: 0, cyc: 56, err: 0, cin: 1'b1};
    tbl[6] = '{len: 6, md: 1, cyc: 47, err: 6, cin: 1'b0};
    tbl[7] = '{len: 1, md: 1, cyc: 7,  err: 1, cin: 1'b0};
    for (int i = 0; i < DEPTH; i++) flt[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_chain_in", chain_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_lat_max", lat_max, 0);

    for (int i = 0; i < DEPTH; i++) cfg_write(i, vals[i], holds[i]);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].len, tbl[i].md, -1, 1'b0, nc, np, wb, bs);
      chk($sformatf("cycles[%0d]", i), nc, tbl[i].cyc);
      chk($sformatf("err_cnt[%0d]", i), err_cnt, tbl[i].err);
      chk($sformatf("pulses[%0d]", i), np, tbl[i].err);
      chk($sformatf("chain_in[%0d]", i), chain_in, tbl[i].cin);
      chk($sformatf("wave[%0d]", i), wb, 0);
      if (tbl[i].len == 0) chk("len0_busy_seen", bs, 0);
    end

    run(4, 0, -1, 1'b1, nc, np, wb, bs);
    chk("busy_start_cycles", nc, 41);
    chk("busy_start_wave", wb, 0);
    run(4, 0, -1, 1'b0, nc, np, wb, bs);
    chk("busy_write_rerun_cycles", nc, 41);
    chk("busy_write_rerun_wave", wb, 0);

    run(4, 1, 25, 1'b0, nc, np, wb, bs);
    chk("midrst_pre_wave", wb, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_chain_in", chain_in, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cur_idx", cur_idx, 0);
    repeat (3) @(posedge clk);
    run(4, 0, -1, 1'b0, nc, np, wb, bs);
    chk("midrst_rerun_cycles", nc, 41);
    chk("midrst_rerun_wave", wb, 0);

    run(5, 0, -1, 1'b0, nc, np, wb, bs);
    chk("sat_main_err", err_cnt, 0);
    chk("sat_err_cnt", s_err, 3);
    chk("sat_done", s_done, 1);

    for (int i = 0; i < 4; i++) cfg_write(i, i[0], 5);
    run(4, 2, -1, 1'b0, nc, np, wb, bs);
    chk("lat_cycles", nc, 28);
    chk("lat_err_cnt", err_cnt, 0);
    chk("lat_max", lat_max, LAT_EXP);
    mode = 0;
    run(0, 0, -1, 1'b0, nc, np, wb, bs);
    chk("lat_clear_on_start", lat_max, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cfg_write(i, 1'($urandom_range(0, 1)), $urandom_range(0, 9));
        flt[i] = 1'($urandom_range(0, 1));
      end
      len = $urandom_range(0, 8);
      run(len, 3, -1, 1'b0, nc, np, wb, bs);
      chk($sformatf("rnd_cycles[%0d]", r), nc, tstart(len));
      chk($sformatf("rnd_err[%0d]", r), err_cnt, exp_err(len, 3, 255));
      chk($sformatf("rnd_pulses[%0d]", r), np, exp_err(len, 3, 255));
      chk($sformatf("rnd_sat_err[%0d]", r), s_err, exp_err(len, 1, 3));
      chk($sformatf("rnd_wave[%0d]", r), wb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_chain_sequencer.md
Name: inv_chain_sequencer

Overview:
Stimulus/check controller for an external chain of STAGES behavioural inverters. Replays a programmed schedule of input levels, each held for a set number of cycles. After each hold it samples the chain output and compares it with the level expected from chain parity. Mismatches are counted. The block replaces hand-written delay stimulus in chain benches and runs under the simulator's clocked mode.

Parameters:
STAGES, 3, inverters in the driven chain; expected output = value XOR STAGES[0]
DEPTH, 8, schedule entries (power of two)
HOLD_W, 8, width of per-entry hold count
ERR_W, 8, width of mismatch counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin run (pulse)
cfg_we  in  1  schedule write strobe
cfg_addr  in  log2(DEPTH)  schedule entry index
cfg_val  in  1  level to apply for that entry
cfg_hold  in  HOLD_W  hold cycles for that entry
cfg_len  in  log2(DEPTH)+1  entries to run, 0..DEPTH, sampled at start
chain_in  out  1  registered drive into chain input
chain_out  in  1  chain output
busy  out  1  run in progress
done  out  1  run finished, held until next accepted start or rst
mismatch  out  1  one-cycle pulse on failed sample
err_cnt  out  ERR_W  mismatches in current/last run
cur_idx  out  log2(DEPTH)  entry being applied
lat_max  out  HOLD_W  see Optional Feature

Behaviour:
- One clock, reset synchronous active-high, as decided.
- Reset values: chain_in=0, busy=0, done=0, mismatch=0, err_cnt=0, cur_idx=0, lat_max=0, state=IDLE.
- rst has priority over everything, including a run in progress. It returns to IDLE in one edge. Schedule RAM contents are not cleared.
- Schedule RAM: DEPTH x (1+HOLD_W). Written on cfg_we only when busy=0; writes while busy are ignored.
- States: IDLE, APPLY, HOLD, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - err_cnt, cur_idx and done clear.
  - cfg_len is latched.
  - len=0: next state DONE, done=1, chain_in unchanged.
  - otherwise: next state APPLY, busy=1.
- start while busy is ignored.
- APPLY (1 cycle): chain_in <= val[cur_idx]. Hold counter <= hold[cur_idx]; a hold of 0 is treated as 1. Next state HOLD.
- HOLD: counter decrements each cycle. On the cycle counter==1, next state is SAMPLE.
- SAMPLE (1 cycle): compares chain_out with val[cur_idx]^STAGES[0].
  - Mismatch: mismatch=1 next cycle, and err_cnt increments, saturating at all-ones.
  - Then cur_idx+1 == len: next state DONE, busy=0, done=1.
  - Otherwise cur_idx increments, next state APPLY.
- Timing per entry: max(hold,1)+2 cycles. chain_in changes exactly on the edge that leaves APPLY's entry edge and is held constant through SAMPLE.
- err_cnt, cur_idx and chain_in keep their values in DONE.
- cur_idx wraps only by run termination; never exceeds len-1.

Optional Feature:
- Macro: INV_CHAIN_LATENCY_EN.
- Defined:
  - A per-entry latency counter resets in APPLY and counts HOLD cycles until chain_out first equals the expected level.
  - In SAMPLE, lat_max <= max(lat_max, latency). An entry that never matched contributes its full hold.
  - lat_max clears on an accepted start.
- Undefined: lat_max is constant 0 and no latency logic is built.

Test Plan:
- rst mid-run (entry 2 of 4, HOLD) -> next cycle busy=0, chain_in=0, err_cnt=0, state IDLE. A following start reruns from entry 0.
- Good chain, schedule {0/5, 1/7, 0/20, 1/1}, len=4 -> chain_in sequence 0,1,0,1 with hold widths 5,7,20,1. done after 41 cycles, err_cnt=0, no mismatch pulses.
- chain_out tied to chain_in (even-parity fault), same schedule -> 4 mismatch pulses, err_cnt=4.
- len=0 start -> done=1 on the next cycle, busy never high, err_cnt=0. Entries with hold=0 behave as hold=1 (3 cycles per entry).
- cfg_we asserted while busy -> RAM unchanged (verified by rerun). start while busy -> ignored. ERR_W=2 with 5 faults -> err_cnt saturates at 3.
- INV_CHAIN_LATENCY_EN, chain model with 3-cycle delay, holds 5 -> lat_max=3. Without the macro -> lat_max=0.
